// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues ROM reads for incoming PCs and buffers
// {pc, word} pairs in a small FIFO for the decoder, with flush support.
module instr_fetch_queue #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pc_valid,
    input  logic [ADDR_W-1:0]          pc_count,
    output logic                       pc_stall,
    output logic                       rom_en,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [INSTR_W-1:0]         rom_data,
    input  logic                       flush,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [INSTR_W-1:0]         instr_data,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = LW + 1;

    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      level;
    logic               inflight;
    logic [ADDR_W-1:0]  issued_addr;
    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic               push, pop;

    // Count the read in flight as occupied so its push always has a slot.
    assign pc_stall    = ({1'b0, level} + SW'(inflight)) >= SW'(DEPTH);
    assign rom_en      = pc_valid & ~pc_stall & ~flush;
    assign rom_addr    = pc_count;

    assign instr_valid = (level != '0) & ~flush;
    assign push        = inflight & ~flush;
    assign pop         = instr_valid & instr_ready;

    assign instr_data  = (level != '0) ? data_mem[rd_ptr] : '0;
    assign instr_pc    = (level != '0) ? pc_mem[rd_ptr]   : '0;
    assign fifo_level  = level;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            inflight    <= 1'b0;
            issued_addr <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            inflight    <= 1'b0;
        end else begin
            inflight    <= rom_en;
            issued_addr <= pc_count;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                level <= level + LW'(1);
            else if (pop && !push)
                level <= level - LW'(1);
        end
    end

    // Storage needs no reset; the outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_mem[wr_ptr] <= rom_data;
            pc_mem[wr_ptr]   <= issued_addr;
        end
    end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, PC/ROM address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pc_valid  input  1  pc_count carries a fetch request this cycle.
REQ-007 SHALL have port pc_count  input  ADDR_W  instruction address from the program counter.
REQ-008 SHALL have port pc_stall  output  1  upstream must hold pc_count; request not accepted.
REQ-009 SHALL have port rom_en  output  1  instruction ROM read strobe.
REQ-010 SHALL have port rom_addr  output  ADDR_W  ROM read address.
REQ-011 SHALL have port rom_data  input  INSTR_W  ROM read data, valid exactly one cycle after rom_en.
REQ-012 SHALL have port flush  input  1  discard all queued and in-flight fetches.
REQ-013 SHALL have port instr_valid  output  1  head entry available to the decoder.
REQ-014 SHALL have port instr_ready  input  1  decoder accepts head entry.
REQ-015 SHALL have port instr_data  output  INSTR_W  head instruction word.
REQ-016 SHALL have port instr_pc  output  ADDR_W  address the head word was fetched from.
REQ-017 SHALL have port fifo_level  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 SHALL assert pc_stall combinationally when fifo_level + inflight >= DEPTH, where inflight is the registered flag of a read issued last cycle.
REQ-019 SHALL drive rom_en = pc_valid & ~pc_stall & ~flush and rom_addr = pc_count.
REQ-020 SHALL register inflight <= rom_en and the issued address each cycle.
REQ-021 SHALL, in the cycle after rom_en, push {issued address, rom_data} into the queue tail unless flush is high that cycle; fetch-to-instr_valid latency is 2 cycles into an empty queue.
REQ-022 SHALL pop the head when instr_valid & instr_ready.
REQ-023 SHALL keep fifo_level unchanged on simultaneous push and pop, and preserve FIFO order.
REQ-024 SHALL drive instr_valid = (fifo_level != 0) & ~flush; instr_data/instr_pc reflect the head entry whenever fifo_level != 0.
REQ-025 SHALL never overflow: by REQ-018 a push always finds a free slot; a pop of an empty queue is impossible by REQ-024.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL, on flush, set fifo_level to 0, clear inflight, reset pointers, and suppress push, pop and rom_en in that cycle; requests are accepted again the next cycle.
REQ-028 SHALL give flush priority over push/pop and rst priority over flush.

Reset
REQ-029 SHALL, while rst is high at a clock edge, clear fifo_level, inflight, and pointers to 0.
REQ-030 SHALL, after reset, present instr_valid=0, pc_stall=0, fifo_level=0, instr_data=0, instr_pc=0; a read in flight at reset is discarded.

Verification
REQ-031 SHALL cover: reset, then pc_valid=1 with pc_count=3, rom_data=16'hA5A5 next cycle -> rom_en=1 at T0, instr_valid=1 at T2 with instr_pc=3, instr_data=16'hA5A5.
REQ-032 SHALL cover: instr_ready=0, pc_valid=1, pc_count 0,1,2,... -> exactly 4 reads issued, pc_stall=1 from the cycle fifo_level+inflight reaches 4, fifo_level=4, no rom_en while stalled.
REQ-033 SHALL cover: full queue, instr_ready=1 for one cycle -> head pc 0 popped, fifo_level=3, pc_stall=0 next cycle, pc_count=4 issued.
REQ-034 SHALL cover: streaming with instr_ready=1 and pc_valid=1 -> one instruction per cycle, fifo_level steady at 1, pcs in order including wrap 31 -> 0.
REQ-035 SHALL cover: flush asserted with 3 entries queued and a read in flight -> next cycle fifo_level=0, instr_valid=0, in-flight data never appears; new fetch of pc 7 appears 2 cycles after issue.
REQ-036 SHALL cover: rst asserted mid-stream with 2 entries queued -> all outputs at REQ-030 values the following cycle.
